// File: rtl/reg_file.sv
// MIPS-style register file: two combinational read ports, one synchronous write port, r0 hardwired to zero.
// Latency: reads are zero-cycle, and writes commit on the rising clk edge. With BYPASS=1 a same-cycle write is visible on the reads.
// Backpressure: none. Every write with wEnable=1 (and rst=0, dR!=0) is accepted.
//
// Ports:
//    clk, rst          single clock; synchronous active-high reset clears every register
//    rA, rB -> aData,  read address / read data for ports A and B (combinational)
//       bData
//    dR, wData,        write address, write data and write enable
//       wEnable
module reg_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rA,
   input  logic [ADDR_W-1:0] rB,
   input  logic [ADDR_W-1:0] dR,
   input  logic [DATA_W-1:0] wData,
   input  logic              wEnable,
   output logic [DATA_W-1:0] aData,
   output logic [DATA_W-1:0] bData
);

   localparam int NREGS = 2 ** ADDR_W;

   // Entry 0 exists so that every address indexes in range. It is never
   // written, and the read muxes force it to zero.
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   // A write is real only when it would actually change state at the edge.
   // The bypass path uses the same qualification so that it never shows a
   // value that will not be committed.
   logic wr_hit;
   assign wr_hit = wEnable && !rst && (dR != '0);

   always_comb begin
      regs_d = regs_q;
      if (wr_hit) begin
         regs_d[dR] = wData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      aData = '0;
      if (rA != '0) begin
         if (BYPASS && wr_hit && (rA == dR)) begin
            aData = wData;
         end else begin
            aData = regs_q[rA];
         end
      end
   end

   always_comb begin
      bData = '0;
      if (rB != '0) begin
         if (BYPASS && wr_hit && (rB == dR)) begin
            bData = wData;
         end else begin
            bData = regs_q[rB];
         end
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file. Each scenario task drives stimulus and checks its own results.
// Inputs change 1 time unit after the rising edge, and outputs are sampled 1 time unit after inputs settle.
// The design has no backpressure. Every wait is a bounded clock tick.
module tb_reg_file;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rA, rB, dR;
   logic [31:0] wData;
   logic        wEnable;
   logic [31:0] aData, bData;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
      .clk     (clk),
      .rst     (rst),
      .rA      (rA),
      .rB      (rB),
      .dR      (dR),
      .wData   (wData),
      .wEnable (wEnable),
      .aData   (aData),
      .bData   (bData)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wEnable = 1'b0; dR = '0; wData = '0; rA = '0; rB = '0;
      tick();
      rst = 1'b0; rA = 5'd1; rB = 5'd31;
      #1;
      checks++;
      if (aData !== 32'h0) begin
         errors++; $display("FAIL reset_aData: got %h expected %h", aData, 32'h0);
      end
      checks++;
      if (bData !== 32'h0) begin
         errors++; $display("FAIL reset_bData: got %h expected %h", bData, 32'h0);
      end
   endtask

   task automatic test_write_read();
      dR = 5'd4; wData = 32'hFFFF_FFFF; wEnable = 1'b1;
      tick();
      wEnable = 1'b0; rA = 5'd4; rB = 5'd1;
      #1;
      checks++;
      if (aData !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL write_read_a: got %h expected %h", aData, 32'hFFFF_FFFF);
      end
      checks++;
      if (bData !== 32'h0) begin
         errors++; $display("FAIL write_read_b: got %h expected %h", bData, 32'h0);
      end
   endtask

   task automatic test_r0_immutable();
      dR = 5'd0; wData = 32'h1234_5678; wEnable = 1'b1; rA = 5'd0; rB = 5'd0;
      #1;
      checks++;
      if (aData !== 32'h0) begin
         errors++; $display("FAIL r0_no_bypass: got %h expected %h", aData, 32'h0);
      end
      tick();
      wEnable = 1'b0;
      #1;
      checks++;
      if (aData !== 32'h0) begin
         errors++; $display("FAIL r0_after_write: got %h expected %h", aData, 32'h0);
      end
   endtask

   task automatic test_write_disabled();
      dR = 5'd7; wData = 32'hDEAD_BEEF; wEnable = 1'b0; rA = 5'd7;
      #1;
      checks++;
      if (aData !== 32'h0) begin
         errors++; $display("FAIL wdis_before_edge: got %h expected %h", aData, 32'h0);
      end
      tick();
      checks++;
      if (aData !== 32'h0) begin
         errors++; $display("FAIL wdis_after_edge: got %h expected %h", aData, 32'h0);
      end
   endtask

   task automatic test_bypass();
      dR = 5'd9; wData = 32'hA5A5_A5A5; wEnable = 1'b1; rA = 5'd9; rB = 5'd9;
      #1;
      checks++;
      if (aData !== 32'hA5A5_A5A5) begin
         errors++; $display("FAIL bypass_a_pre: got %h expected %h", aData, 32'hA5A5_A5A5);
      end
      checks++;
      if (bData !== 32'hA5A5_A5A5) begin
         errors++; $display("FAIL bypass_b_pre: got %h expected %h", bData, 32'hA5A5_A5A5);
      end
      // While the write is still pending, a read of a different register is independent of it.
      rB = 5'd4;
      #1;
      checks++;
      if (bData !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL bypass_indep_b: got %h expected %h", bData, 32'hFFFF_FFFF);
      end
      rB = 5'd9;
      tick();
      wEnable = 1'b0; wData = 32'h0;
      #1;
      checks++;
      if (aData !== 32'hA5A5_A5A5) begin
         errors++; $display("FAIL bypass_a_post: got %h expected %h", aData, 32'hA5A5_A5A5);
      end
      checks++;
      if (bData !== 32'hA5A5_A5A5) begin
         errors++; $display("FAIL bypass_b_post: got %h expected %h", bData, 32'hA5A5_A5A5);
      end
   endtask

   task automatic test_reset_priority();
      rst = 1'b1; wEnable = 1'b1; dR = 5'd4; wData = 32'h0000_0001; rA = 5'd4; rB = 5'd9;
      #1;
      // While rst is high, the write is suppressed, so the bypass path must not apply.
      checks++;
      if (aData !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL rstpri_no_bypass: got %h expected %h", aData, 32'hFFFF_FFFF);
      end
      tick();
      rst = 1'b0; wEnable = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rA = 5'(i); rB = 5'(31 - i);
         #1;
         checks++;
         if (aData !== 32'h0) begin
            errors++; $display("FAIL rstpri_clear_a[%0d]: got %h expected %h", i, aData, 32'h0);
         end
         checks++;
         if (bData !== 32'h0) begin
            errors++; $display("FAIL rstpri_clear_b[%0d]: got %h expected %h", 31 - i, bData, 32'h0);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] idx;
      logic [31:0] exp_a, exp_b;
      // Write every register on consecutive edges with a value that encodes its index.
      wEnable = 1'b1;
      for (int i = 1; i < 32; i++) begin
         idx = 5'(i);
         dR = idx; wData = {8'h5A, 3'b000, idx, 8'hC3, 3'b000, ~idx};
         tick();
      end
      wEnable = 1'b0; dR = '0; wData = '0;
      for (int i = 0; i < 32; i++) begin
         idx = 5'(i);
         rA = idx; rB = ~idx;
         exp_a = (i == 0) ? 32'h0 : {8'h5A, 3'b000, idx, 8'hC3, 3'b000, ~idx};
         exp_b = (i == 31) ? 32'h0 : {8'h5A, 3'b000, ~idx, 8'hC3, 3'b000, idx};
         #1;
         checks++;
         if (aData !== exp_a) begin
            errors++; $display("FAIL b2b_a[%0d]: got %h expected %h", i, aData, exp_a);
         end
         checks++;
         if (bData !== exp_b) begin
            errors++; $display("FAIL b2b_b[%0d]: got %h expected %h", 31 - i, bData, exp_b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_r0_immutable();
      test_write_disabled();
      test_bypass();
      test_reset_priority();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
